// File: rtl/multih_pkg.sv
// Shared constants, coefficient table and arithmetic helpers for the multi-h CPM phase de-rotator.
package multih_pkg;

    localparam int DW     = 18;          // I/Q sample width, Q1.17
    localparam int SELW   = 5;           // phase-select width
    localparam int CW     = 18;          // cos/sin coefficient width, Q1.17
    localparam int PW     = DW + CW;     // full product width
    localparam int SW     = PW + 1;      // sum of two products
    localparam int FINE_N = 1 << (SELW - 2);
    localparam int OCT_N  = FINE_N / 2;

    localparam int SAT_MAX = 131071;
    localparam int SAT_MIN = -131071;

    // First-octant cos/sin, round(x * 2^17); cos(0) is clipped to the largest positive code.
    localparam logic signed [CW-1:0] COS_TAB [0:OCT_N] = '{
        18'sh1FFFF, 18'sh1F629, 18'sh1D907, 18'sh1A9B6, 18'sh16A0A
    };
    localparam logic signed [CW-1:0] SIN_TAB [0:OCT_N] = '{
        18'sh00000, 18'sh063E3, 18'sh0C3EF, 18'sh11C74, 18'sh16A0A
    };

    localparam logic signed [SW-1:0] RND_HALF = SW'(1) <<< (CW - 2);
    localparam logic signed [DW-1:0] NEG_FULL = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        QUAD_0   = 2'd0,
        QUAD_90  = 2'd1,
        QUAD_180 = 2'd2,
        QUAD_270 = 2'd3
    } quadrant_e;

    // Negation that maps the most negative code to the largest positive one.
    function automatic logic signed [DW-1:0] negSat(input logic signed [DW-1:0] x);
        logic signed [DW-1:0] result;
        if (x == NEG_FULL) begin
            result = DW'(SAT_MAX);
        end else begin
            result = -x;
        end
        return result;
    endfunction

    // Round half up back to Q1.17, then clip to the symmetric output range.
    function automatic logic signed [DW-1:0] roundSat(input logic signed [SW-1:0] acc);
        logic signed [SW-1:0] rounded;
        logic signed [DW-1:0] result;
        rounded = (acc + RND_HALF) >>> (CW - 1);
        if (rounded > SW'(SAT_MAX)) begin
            result = DW'(SAT_MAX);
        end else if (rounded < SW'(SAT_MIN)) begin
            result = DW'(SAT_MIN);
        end else begin
            result = rounded[DW-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/multi_h_rotator_if.sv
// Sample/phase-select bus into the de-rotator and the rotated result coming back.
interface multi_h_rotator_if;
    import multih_pkg::*;

    logic                   symEn;
    logic signed [DW-1:0]   i;
    logic signed [DW-1:0]   q;
    logic [SELW-1:0]        sel;
    logic signed [DW-1:0]   iOut;
    logic signed [DW-1:0]   qOut;

    modport master (
        output symEn, i, q, sel,
        input  iOut, qOut
    );

    modport slave (
        input  symEn, i, q, sel,
        output iOut, qOut
    );

endinterface

// File: rtl/multih_trig_rom.sv
// Fine-phase cos/sin lookup: first-octant table mirrored to cover all eight sub-quadrant steps.
module multih_trig_rom
    import multih_pkg::*;
(
    input  logic [SELW-3:0]        m,
    output logic signed [CW-1:0]   c,
    output logic signed [CW-1:0]   s
);

    logic signed [CW-1:0] cosFull [FINE_N];
    logic signed [CW-1:0] sinFull [FINE_N];

    genvar gi;
    generate
        for (gi = 0; gi < FINE_N; gi++) begin : gFine
            if (gi <= OCT_N) begin : gDirect
                assign cosFull[gi] = COS_TAB[gi];
                assign sinFull[gi] = SIN_TAB[gi];
            end else begin : gMirror
                // Beyond 45 deg cos and sin swap roles of the complementary angle.
                assign cosFull[gi] = SIN_TAB[FINE_N - gi];
                assign sinFull[gi] = COS_TAB[FINE_N - gi];
            end
        end
    endgenerate

    assign c = cosFull[m];
    assign s = sinFull[m];

endmodule

// File: rtl/multi_h_rotator.sv
// Three-stage complex de-rotator: capture, exact quadrant step plus fine multiply, round/saturate.
module multi_h_rotator
    import multih_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    multi_h_rotator_if.slave    bus
);

    logic signed [DW-1:0]   iReg;
    logic signed [DW-1:0]   qReg;
    logic [SELW-1:0]        selReg;
    logic                   valid1;

    logic signed [PW-1:0]   prodIC;
    logic signed [PW-1:0]   prodQS;
    logic signed [PW-1:0]   prodQC;
    logic signed [PW-1:0]   prodIS;
    logic                   valid2;

    logic signed [DW-1:0]   iOutReg;
    logic signed [DW-1:0]   qOutReg;

    quadrant_e              quadrant;
    logic signed [DW-1:0]   iRot;
    logic signed [DW-1:0]   qRot;
    logic signed [CW-1:0]   cVal;
    logic signed [CW-1:0]   sVal;
    logic signed [SW-1:0]   accI;
    logic signed [SW-1:0]   accQ;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iReg   <= '0;
            qReg   <= '0;
            selReg <= '0;
            valid1 <= 1'b0;
        end else begin
            valid1 <= bus.symEn;
            if (bus.symEn) begin
                iReg   <= bus.i;
                qReg   <= bus.q;
                selReg <= bus.sel;
            end
        end
    end

    // Multiplying by -j per quadrant is a swap plus a saturating negate.
    always_comb begin
        iRot     = iReg;
        qRot     = qReg;
        quadrant = quadrant_e'(selReg[SELW-1:SELW-2]);
        case (quadrant)
            QUAD_0: begin
                iRot = iReg;
                qRot = qReg;
            end
            QUAD_90: begin
                iRot = qReg;
                qRot = negSat(iReg);
            end
            QUAD_180: begin
                iRot = negSat(iReg);
                qRot = negSat(qReg);
            end
            QUAD_270: begin
                iRot = negSat(qReg);
                qRot = iReg;
            end
            default: begin
                iRot = iReg;
                qRot = qReg;
            end
        endcase
    end

    multih_trig_rom trigRom (
        .m (selReg[SELW-3:0]),
        .c (cVal),
        .s (sVal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prodIC <= '0;
            prodQS <= '0;
            prodQC <= '0;
            prodIS <= '0;
            valid2 <= 1'b0;
        end else begin
            prodIC <= PW'(iRot) * PW'(cVal);
            prodQS <= PW'(qRot) * PW'(sVal);
            prodQC <= PW'(qRot) * PW'(cVal);
            prodIS <= PW'(iRot) * PW'(sVal);
            valid2 <= valid1;
        end
    end

    // (I + jQ)(c - js) = (Ic + Qs) + j(Qc - Is)
    always_comb begin
        accI = SW'(prodIC) + SW'(prodQS);
        accQ = SW'(prodQC) - SW'(prodIS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iOutReg <= '0;
            qOutReg <= '0;
        end else if (valid2) begin
            iOutReg <= roundSat(accI);
            qOutReg <= roundSat(accQ);
        end
    end

    assign bus.iOut = iOutReg;
    assign bus.qOut = qOutReg;

endmodule

// File: tb/tb_multi_h_rotator.sv
// Directed vector bench for multi_h_rotator: table of hand-computed rotations plus reset and sweep sequences.
module tb_multi_h_rotator;
    import multih_pkg::*;

    localparam int NV = 12;

    typedef struct packed {
        logic [17:0] i;
        logic [17:0] q;
        logic [4:0]  sel;
        logic [17:0] expI;
        logic [17:0] expQ;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   nCmp = 0;
    int   nBad = 0;
    vec_t vecs [NV];

    multi_h_rotator_if bus ();

    multi_h_rotator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5ns clk = ~clk;

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got 0x%05h, expected 0x%05h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%05h", name, act);
        end
    endtask

    task automatic drive(input logic en, input logic [17:0] iv, input logic [17:0] qv, input logic [4:0] sv);
        bus.symEn = en;
        bus.i     = iv;
        bus.q     = qv;
        bus.sel   = sv;
    endtask

    initial begin
        real   magIn;
        real   magOut;
        real   ang;
        real   expAng;
        real   diff;
        int    gap;
        logic [4:0] sv;

        vecs[0]  = '{i:18'h10000, q:18'h00000, sel:5'd0,  expI:18'h10000, expQ:18'h00000};
        vecs[1]  = '{i:18'h10000, q:18'h00000, sel:5'd4,  expI:18'h0B505, expQ:18'h34AFB};
        vecs[2]  = '{i:18'h10000, q:18'h00000, sel:5'd8,  expI:18'h00000, expQ:18'h30001};
        vecs[3]  = '{i:18'h1FFFF, q:18'h1FFFF, sel:5'd4,  expI:18'h1FFFF, expQ:18'h00000};
        vecs[4]  = '{i:18'h10000, q:18'h00000, sel:5'd16, expI:18'h30001, expQ:18'h00000};
        vecs[5]  = '{i:18'h10000, q:18'h00000, sel:5'd24, expI:18'h00000, expQ:18'h10000};
        vecs[6]  = '{i:18'h20000, q:18'h00000, sel:5'd16, expI:18'h1FFFE, expQ:18'h00000};
        vecs[7]  = '{i:18'h20001, q:18'h20001, sel:5'd4,  expI:18'h20001, expQ:18'h00000};
        vecs[8]  = '{i:18'h00000, q:18'h10000, sel:5'd1,  expI:18'h031F2, expQ:18'h0FB15};
        vecs[9]  = '{i:18'h10000, q:18'h00000, sel:5'd31, expI:18'h0FB15, expQ:18'h031F2};
        vecs[10] = '{i:18'h10000, q:18'h00000, sel:5'd6,  expI:18'h061F8, expQ:18'h3137D};
        vecs[11] = '{i:18'h10000, q:18'h00000, sel:5'd2,  expI:18'h0EC84, expQ:18'h39E09};

        drive(1'b0, 18'h0, 18'h0, 5'd0);

        // Asynchronous reset takes effect between clock edges.
        #1ns reset = 1'b1;
        #1ns;
        check("reset iOut", bus.iOut, 18'h0);
        check("reset qOut", bus.qOut, 18'h0);
        #100ns;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1ns;
        check("idle after reset iOut", bus.iOut, 18'h0);
        check("idle after reset qOut", bus.qOut, 18'h0);

        // Back-to-back table: vector k captured at iteration k, visible at iteration k+2.
        for (int k = 0; k < NV + 2; k++) begin
            @(negedge clk);
            if (k < NV) drive(1'b1, vecs[k].i, vecs[k].q, vecs[k].sel);
            else        drive(1'b0, 18'h15555, 18'h2AAAA, 5'd13);
            @(posedge clk);
            #1ns;
            if (k >= 2) begin
                check($sformatf("vec%0d sel=%0d iOut", k - 2, vecs[k-2].sel), bus.iOut, vecs[k-2].expI);
                check($sformatf("vec%0d sel=%0d qOut", k - 2, vecs[k-2].sel), bus.qOut, vecs[k-2].expQ);
            end
        end

        repeat (4) @(posedge clk);
        #1ns;
        check("hold iOut", bus.iOut, vecs[NV-1].expI);
        check("hold qOut", bus.qOut, vecs[NV-1].expQ);

        // Reset between edges clears a live output immediately.
        @(negedge clk);
        #2ns reset = 1'b1;
        #1ns;
        check("async reset iOut", bus.iOut, 18'h0);
        check("async reset qOut", bus.qOut, 18'h0);
        #100ns;
        @(negedge clk);
        reset = 1'b0;

        // A sample in flight when reset arrives must never appear.
        @(negedge clk);
        drive(1'b1, 18'h10000, 18'h00000, 5'd0);
        @(posedge clk);
        #1ns drive(1'b0, 18'h0, 18'h0, 5'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1ns;
        check("in-flight discard iOut", bus.iOut, 18'h0);
        check("in-flight discard qOut", bus.qOut, 18'h0);

        // symEn held high across edges while reset is asserted is ignored.
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 18'h10000, 18'h00000, 5'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 18'h0, 18'h0, 5'd0);
        repeat (4) @(posedge clk);
        #1ns;
        check("symEn during reset iOut", bus.iOut, 18'h0);
        check("symEn during reset qOut", bus.qOut, 18'h0);

        // Sparse sweep through every phase with wrap-around.
        magIn = $sqrt(128553.0 * 128553.0 + 25571.0 * 25571.0);
        for (int k = 0; k < 34; k++) begin
            sv  = 5'(k % 32);
            gap = (k % 2 == 0) ? 7 : 14;
            @(negedge clk);
            drive(1'b1, 18'h1F629, 18'h063E3, sv);
            @(posedge clk);
            #1ns drive(1'b0, 18'h0, 18'h0, 5'd0);
            repeat (2) @(posedge clk);
            #1ns;
            nCmp++;
            if ($isunknown(bus.iOut) || $isunknown(bus.qOut)) begin
                nBad++;
                $display("FAIL sweep%0d X: iOut=%h qOut=%h, expected known values", k, bus.iOut, bus.qOut);
            end else begin
                magOut = $sqrt($itor(bus.iOut) * $itor(bus.iOut) + $itor(bus.qOut) * $itor(bus.qOut));
                ang    = $atan2($itor(bus.qOut), $itor(bus.iOut)) * 180.0 / 3.14159265358979;
                expAng = 11.25 - 11.25 * k;
                diff   = ang - expAng;
                while (diff > 180.0)   diff = diff - 360.0;
                while (diff < -180.0)  diff = diff + 360.0;
                if ((magOut - magIn > 2.0) || (magIn - magOut > 2.0)) begin
                    nBad++;
                    $display("FAIL sweep%0d sel=%0d magnitude: got %f, expected %f +/-2", k, sv, magOut, magIn);
                end else begin
                    $display("ok   sweep%0d sel=%0d magnitude %f", k, sv, magOut);
                end
                nCmp++;
                if ((diff > 0.02) || (diff < -0.02)) begin
                    nBad++;
                    $display("FAIL sweep%0d sel=%0d phase: got %f deg, expected %f deg", k, sv, ang, expAng);
                end else begin
                    $display("ok   sweep%0d sel=%0d phase %f deg", k, sv, ang);
                end
            end
            repeat (gap - 3) @(posedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
